// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, special instruction encodings and the
// constant jump-target table (also consumed by the assembler).
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [8:0] HALT_INSTR = 9'h1FF;
  localparam logic [8:0] NOP_INSTR  = 9'h000;

  // Ascending range so the leftmost entry is index 0.
  localparam logic [0:15][7:0] JUMP_LUT = '{
    8'h20, 8'h30, 8'hFE, 8'h40,
    8'h80, 8'h90, 8'hA0, 8'hB0,
    8'hC0, 8'hD0, 8'hE0, 8'h10,
    8'h50, 8'h60, 8'h70, 8'hF0
  };

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and IF/ID-facing outputs.
interface fetch_stage_if #(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned INSTR_W   = 9,
  parameter int unsigned LUT_IDX_W = 4
);

  logic                 start;
  logic                 stall;
  logic                 branch_taken;
  logic [LUT_IDX_W-1:0] branch_idx;
  logic [INSTR_W-1:0]   imem_data;
  logic [PC_W-1:0]      imem_addr;
  logic [PC_W-1:0]      PC_out;
  logic [INSTR_W-1:0]   instr_out;
  logic                 flush_out;
  logic                 done;
  logic [15:0]          fetch_count;

  modport master (
    input  start, stall, branch_taken, branch_idx, imem_data,
    output imem_addr, PC_out, instr_out, flush_out, done, fetch_count
  );

  modport slave (
    output start, stall, branch_taken, branch_idx, imem_data,
    input  imem_addr, PC_out, instr_out, flush_out, done, fetch_count
  );

endinterface

// File: rtl/fetch_stage_pc_next.sv
// Combinational next-PC selection: branch redirect > HALT match > stall > increment.
module pc_next
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned INSTR_W   = 9,
  parameter int unsigned LUT_IDX_W = 4
) (
  input  logic                 run_i,
  input  logic [PC_W-1:0]      pc_i,
  input  logic                 stall_i,
  input  logic                 branch_taken_i,
  input  logic [LUT_IDX_W-1:0] branch_idx_i,
  input  logic [INSTR_W-1:0]   instr_i,
  output logic [PC_W-1:0]      pc_d_o,
  output logic                 halt_o,
  output logic                 advance_o,
  output logic                 flush_o
);

  always_comb begin
    pc_d_o    = pc_i;
    halt_o    = 1'b0;
    advance_o = 1'b0;
    flush_o   = 1'b0;
    if (run_i) begin
      if (branch_taken_i) begin
        pc_d_o  = PC_W'(JUMP_LUT[branch_idx_i]);
        flush_o = 1'b1;
      end else if (instr_i == INSTR_W'(HALT_INSTR)) begin
        halt_o = 1'b1;
      end else if (!stall_i) begin
        pc_d_o    = pc_i + PC_W'(1);
        advance_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the IDLE/RUN/HALT FSM and the issue counter,
// and drives the PC/instruction pair plus flush into IF/ID.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned INSTR_W   = 9,
  parameter int unsigned LUT_IDX_W = 4
) (
  input  logic          CLK,
  input  logic          reset,
  fetch_stage_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            run;
  logic [PC_W-1:0] pc_sel;
  logic            halt_hit;
  logic            advance;
  logic            flush;

  assign run = (state_q == RUN);

  pc_next #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_pc_next (
    .run_i          (run),
    .pc_i           (pc_q),
    .stall_i        (bus.stall),
    .branch_taken_i (bus.branch_taken),
    .branch_idx_i   (bus.branch_idx),
    .instr_i        (bus.imem_data),
    .pc_d_o         (pc_sel),
    .halt_o         (halt_hit),
    .advance_o      (advance),
    .flush_o        (flush)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        pc_d = pc_sel;
        if (halt_hit) begin
          state_d = HALT;
        end
        if (advance && (cnt_q != '1)) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  assign bus.imem_addr   = pc_q;
  assign bus.PC_out      = pc_q;
  assign bus.instr_out   = run ? bus.imem_data : INSTR_W'(NOP_INSTR);
  assign bus.flush_out   = flush;
  assign bus.done        = (state_q == HALT);
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational instruction memory model.
module tb_fetch_stage;

  logic       CLK = 1'b0;
  logic       reset;
  logic [8:0] mem [256];
  int         n_checks = 0;
  int         n_fail   = 0;

  fetch_stage_if #(.PC_W(8), .INSTR_W(9), .LUT_IDX_W(4)) bus ();

  fetch_stage #(.PC_W(8), .INSTR_W(9), .LUT_IDX_W(4)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  assign bus.imem_data = mem[bus.imem_addr];

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    for (int unsigned i = 0; i < 256; i++) mem[i] = 9'(i + 1);
    reset = 1'b1;
    bus.start = 1'b0; bus.stall = 1'b0; bus.branch_taken = 1'b1; bus.branch_idx = 4'd0;
    #3;
    n_checks++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", bus.imem_addr); end
    n_checks++; if (bus.instr_out !== 9'h000) begin n_fail++; $display("FAIL reset_instr: got %h expected 000", bus.instr_out); end
    n_checks++; if (bus.flush_out !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b expected 0", bus.flush_out); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.fetch_count !== 16'h0000) begin n_fail++; $display("FAIL reset_count: got %h expected 0000", bus.fetch_count); end
    bus.branch_taken = 1'b0;
    @(negedge CLK);
    reset = 1'b0;
    next_cycle();
    next_cycle();
    n_checks++; if (bus.PC_out !== 8'h00 || bus.instr_out !== 9'h000) begin n_fail++; $display("FAIL idle_hold: got pc %h instr %h expected 00 000", bus.PC_out, bus.instr_out); end
  endtask

  task automatic test_start_sequence();
    @(negedge CLK);
    bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      n_checks++; if (bus.imem_addr !== 8'(k) || bus.PC_out !== 8'(k)) begin n_fail++; $display("FAIL seq_pc%0d: got addr %h pc %h expected %h", k, bus.imem_addr, bus.PC_out, 8'(k)); end
      n_checks++; if (bus.instr_out !== 9'(k + 1)) begin n_fail++; $display("FAIL seq_instr%0d: got %h expected %h", k, bus.instr_out, 9'(k + 1)); end
      n_checks++; if (bus.fetch_count !== 16'(k)) begin n_fail++; $display("FAIL seq_count%0d: got %0d expected %0d", k, bus.fetch_count, k); end
      next_cycle();
    end
    next_cycle();
  endtask

  task automatic test_stall();
    n_checks++; if (bus.PC_out !== 8'h05) begin n_fail++; $display("FAIL stall_entry: got %h expected 05", bus.PC_out); end
    bus.stall = 1'b1;
    next_cycle();
    n_checks++; if (bus.PC_out !== 8'h05 || bus.fetch_count !== 16'd5) begin n_fail++; $display("FAIL stall_hold1: got pc %h cnt %0d expected 05 5", bus.PC_out, bus.fetch_count); end
    next_cycle();
    bus.stall = 1'b0;
    n_checks++; if (bus.PC_out !== 8'h05 || bus.fetch_count !== 16'd5) begin n_fail++; $display("FAIL stall_hold2: got pc %h cnt %0d expected 05 5", bus.PC_out, bus.fetch_count); end
    next_cycle();
    n_checks++; if (bus.PC_out !== 8'h06 || bus.fetch_count !== 16'd6) begin n_fail++; $display("FAIL stall_release: got pc %h cnt %0d expected 06 6", bus.PC_out, bus.fetch_count); end
  endtask

  task automatic test_branch_stall();
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_idx = 4'd3;
    #1;
    n_checks++; if (bus.flush_out !== 1'b1 || bus.PC_out !== 8'h06) begin n_fail++; $display("FAIL br_flush: got flush %b pc %h expected 1 06", bus.flush_out, bus.PC_out); end
    next_cycle();
    bus.stall = 1'b0; bus.branch_taken = 1'b0;
    #1;
    n_checks++; if (bus.PC_out !== 8'h40 || bus.instr_out !== 9'h041) begin n_fail++; $display("FAIL br_target: got pc %h instr %h expected 40 041", bus.PC_out, bus.instr_out); end
    n_checks++; if (bus.flush_out !== 1'b0 || bus.fetch_count !== 16'd6) begin n_fail++; $display("FAIL br_after: got flush %b cnt %0d expected 0 6", bus.flush_out, bus.fetch_count); end
  endtask

  task automatic test_halt_shadow();
    mem[8'h40] = 9'h1FF;
    bus.branch_taken = 1'b1; bus.branch_idx = 4'd0;
    #1;
    n_checks++; if (bus.instr_out !== 9'h1FF || bus.flush_out !== 1'b1) begin n_fail++; $display("FAIL shadow_fetch: got instr %h flush %b expected 1ff 1", bus.instr_out, bus.flush_out); end
    next_cycle();
    bus.branch_taken = 1'b0;
    mem[8'h40] = 9'h041;
    n_checks++; if (bus.PC_out !== 8'h20 || bus.done !== 1'b0) begin n_fail++; $display("FAIL shadow_redirect: got pc %h done %b expected 20 0", bus.PC_out, bus.done); end
    next_cycle();
    n_checks++; if (bus.PC_out !== 8'h21 || bus.done !== 1'b0 || bus.fetch_count !== 16'd7) begin n_fail++; $display("FAIL shadow_run: got pc %h done %b cnt %0d expected 21 0 7", bus.PC_out, bus.done, bus.fetch_count); end
  endtask

  task automatic test_wrap_and_reset();
    bus.branch_taken = 1'b1; bus.branch_idx = 4'd2;
    next_cycle();
    bus.branch_taken = 1'b0;
    n_checks++; if (bus.PC_out !== 8'hFE || bus.fetch_count !== 16'd7) begin n_fail++; $display("FAIL wrap_fe: got pc %h cnt %0d expected fe 7", bus.PC_out, bus.fetch_count); end
    next_cycle();
    n_checks++; if (bus.PC_out !== 8'hFF || bus.instr_out !== 9'h100) begin n_fail++; $display("FAIL wrap_ff: got pc %h instr %h expected ff 100", bus.PC_out, bus.instr_out); end
    next_cycle();
    n_checks++; if (bus.PC_out !== 8'h00 || bus.fetch_count !== 16'd9) begin n_fail++; $display("FAIL wrap_00: got pc %h cnt %0d expected 00 9", bus.PC_out, bus.fetch_count); end
    next_cycle();
    #2;
    bus.branch_taken = 1'b1;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.PC_out !== 8'h00 || bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL midreset_pc: got pc %h addr %h expected 00 00", bus.PC_out, bus.imem_addr); end
    n_checks++; if (bus.instr_out !== 9'h000 || bus.flush_out !== 1'b0) begin n_fail++; $display("FAIL midreset_out: got instr %h flush %b expected 000 0", bus.instr_out, bus.flush_out); end
    n_checks++; if (bus.done !== 1'b0 || bus.fetch_count !== 16'h0000) begin n_fail++; $display("FAIL midreset_state: got done %b cnt %0d expected 0 0", bus.done, bus.fetch_count); end
    bus.branch_taken = 1'b0;
    @(negedge CLK);
    reset = 1'b0;
    next_cycle();
    n_checks++; if (bus.PC_out !== 8'h00 || bus.instr_out !== 9'h000) begin n_fail++; $display("FAIL midreset_idle: got pc %h instr %h expected 00 000", bus.PC_out, bus.instr_out); end
  endtask

  task automatic test_halt();
    mem[7] = 9'h1FF;
    @(negedge CLK);
    bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    for (int unsigned k = 0; k < 7; k++) next_cycle();
    n_checks++; if (bus.PC_out !== 8'h07 || bus.instr_out !== 9'h1FF || bus.done !== 1'b0) begin n_fail++; $display("FAIL halt_fetch: got pc %h instr %h done %b expected 07 1ff 0", bus.PC_out, bus.instr_out, bus.done); end
    next_cycle();
    n_checks++; if (bus.done !== 1'b1 || bus.PC_out !== 8'h07 || bus.instr_out !== 9'h000) begin n_fail++; $display("FAIL halt_enter: got done %b pc %h instr %h expected 1 07 000", bus.done, bus.PC_out, bus.instr_out); end
    n_checks++; if (bus.fetch_count !== 16'd7) begin n_fail++; $display("FAIL halt_count: got %0d expected 7", bus.fetch_count); end
    bus.branch_taken = 1'b1;
    #1;
    n_checks++; if (bus.flush_out !== 1'b0) begin n_fail++; $display("FAIL halt_flush: got %b expected 0", bus.flush_out); end
    bus.branch_taken = 1'b0;
    @(negedge CLK);
    bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    next_cycle();
    n_checks++; if (bus.done !== 1'b1 || bus.imem_addr !== 8'h07 || bus.fetch_count !== 16'd7) begin n_fail++; $display("FAIL halt_start_ignored: got done %b addr %h cnt %0d expected 1 07 7", bus.done, bus.imem_addr, bus.fetch_count); end
    mem[7] = 9'h008;
  endtask

  initial begin
    test_reset();
    test_start_sequence();
    test_stall();
    test_branch_stall();
    test_halt_shadow();
    test_wrap_and_reset();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage, directly upstream of the IF/ID pipeline register. It owns the program counter and the IDLE/RUN/HALT fetch state machine. It resolves branch redirects through a constant jump-target LUT and drives the PC/instruction pair plus the flush strobe into IF/ID. Instruction memory is external, with a combinational read.

## Interface
Parameters:
- PC_W, 8, program counter width
- INSTR_W, 9, instruction width
- LUT_IDX_W, 4, jump-target LUT index width (16 entries)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  single-cycle pulse; begins execution from PC 0
- stall  in  1  hazard stall from decode; hold the PC
- branch_taken  in  1  branch resolved taken this cycle
- branch_idx  in  LUT_IDX_W  jump-LUT index of the taken branch
- imem_data  in  INSTR_W  instruction at imem_addr, combinational
- imem_addr  out  PC_W  current PC to instruction memory
- PC_out  out  PC_W  to IF/ID PC_in
- instr_out  out  INSTR_W  to IF/ID instr_in
- flush_out  out  1  to IF/ID flush
- done  out  1  program halted
- fetch_count  out  16  instructions issued since start, saturating

## Operation
- **States:** IDLE (reset state), RUN, HALT. "Fetch" below means a cycle in which the state is RUN.
- **IDLE:**
  - PC held at 0.
  - instr_out = NOP (all zeros).
  - flush_out = 0, done = 0.
  - On start = 1: go to RUN, clear fetch_count. PC stays 0, so the first fetched instruction is at PC 0.
- **RUN:**
  - imem_addr = PC_out = PC, and instr_out = imem_data.
  - The next PC is chosen by this priority, highest first:
    1. branch_taken: PC ← JUMP_LUT[branch_idx], flush_out = 1.
    2. imem_data == HALT_INSTR: state → HALT, PC held.
    3. stall: PC held.
    4. Otherwise: PC ← PC + 1, modulo 2^PC_W (8'hFF wraps to 8'h00).
- **fetch_count:** increments (saturating at 16'hFFFF) on every RUN cycle with no stall, no branch_taken and no HALT match.
- **HALT:**
  - instr_out = NOP, flush_out = 0, done = 1.
  - PC frozen. The HALT instruction itself is still presented to IF/ID for its single fetch cycle.
  - Only reset exits HALT; start is ignored.
- **start in RUN or HALT:** ignored.
- **flush_out:** combinational, equal to branch_taken AND state == RUN. It is 0 in IDLE and HALT.
- **Branch vs. stall:** a branch on a stall cycle still redirects. The branch outranks the stall.
- **Branch vs. HALT:** a HALT fetched in a branch shadow does not halt, because the redirect wins.
- **Reset mid-operation:** the state returns to IDLE within the same cycle, asynchronously. Outputs immediately take their reset values.

## Timing
- Reset values:
  - PC = 0, state = IDLE, fetch_count = 0.
  - imem_addr = 0, PC_out = 0, instr_out = 0, flush_out = 0, done = 0.
- The PC register updates at the rising edge. imem_addr, PC_out and instr_out follow the PC combinationally within the same cycle.
- start sampled at edge N gives the PC 0 fetch during cycle N+1.
- branch_taken asserted in cycle N:
  - flush_out is high in cycle N, so IF/ID clears at edge N.
  - The target instruction is presented in cycle N+1.
- HALT_INSTR on imem_data in cycle N: done is high from cycle N+1 onward.
- No registered outputs other than those derived from the PC and state; latency from PC to instruction is zero cycles.

## Structure
- Shared package cpu_pkg holds:
  - the fetch_state_t enum: IDLE, RUN, HALT
  - HALT_INSTR = 9'h1FF
  - NOP_INSTR = 9'h000
  - JUMP_LUT: a constant array of 16 × 8-bit targets, also used by the assembler
- Sub-module pc_next: combinational next-PC/priority selection, including the LUT lookup. It is kept separate so it can be checked exhaustively on its own.
- The state machine and counter live in fetch_stage.

## Test plan
- **Reset then start:** assert reset, release it, pulse start, with memory holding sequential non-HALT words. Required: imem_addr reads 0, 1, 2, 3 on consecutive cycles, and fetch_count = 3 after the fourth fetch edge.
- **Stall:** stall high for 2 cycles at PC 5. Required: PC holds at 5 for both cycles, then goes to 6; fetch_count does not increment during the stall.
- **Branch with stall:** branch_taken = 1, branch_idx = 3 with JUMP_LUT[3] = 8'h40, while stall = 1. Required: flush_out = 1 in that cycle, and PC = 8'h40 on the next cycle.
- **HALT:** HALT_INSTR at PC 7. Required: done rises on the next cycle; PC stays 7, instr_out = 0, and a later start is ignored.
- **HALT in branch shadow:** HALT_INSTR at the current PC while branch_taken = 1. Required: the redirect occurs and done stays 0.
- **Wrap and mid-run reset:**
  - Run from PC 8'hFE with no stalls. Required: PC goes 8'hFF then 8'h00.
  - Assert reset mid-cycle during RUN. Required: PC and all outputs are 0 immediately, and the state is IDLE.
